// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file: operation/enable/data inputs and the two read ports.
interface param_register_file_if #(
    parameter int unsigned Width = 16,
    parameter int unsigned NRegs = 4,
    parameter int unsigned SelW  = $clog2(NRegs)
);
    logic [3:0]       fun_sel;
    logic [NRegs-1:0] reg_sel;
    logic [Width-1:0] data;
    logic [SelW-1:0]  out_a_sel;
    logic [SelW-1:0]  out_b_sel;
    logic [Width-1:0] out_a;
    logic [Width-1:0] out_b;
    logic             zero_a;
    logic             wrap;

    modport master (
        output fun_sel, reg_sel, data, out_a_sel, out_b_sel,
        input  out_a, out_b, zero_a, wrap
    );

    modport slave (
        input  fun_sel, reg_sel, data, out_a_sel, out_b_sel,
        output out_a, out_b, zero_a, wrap
    );
endinterface

// File: rtl/param_register_file.sv
// Bank of NRegs registers sharing one input bus, with FunSel ops, shifts/rotates,
// two combinational read ports and a registered increment/decrement wrap pulse.
module param_register_file #(
    parameter int unsigned Width = 16,
    parameter int unsigned NRegs = 4,
    parameter int unsigned SelW  = $clog2(NRegs)
) (
    input logic                  clk_i,
    input logic                  rst_i,
    param_register_file_if.slave bus
);

    typedef enum logic [3:0] {
        FsDec    = 4'b0000,
        FsInc    = 4'b0001,
        FsLoad   = 4'b0010,
        FsClear  = 4'b0011,
        FsZext   = 4'b0100,
        FsLoadLo = 4'b0101,
        FsLoadHi = 4'b0110,
        FsSext   = 4'b0111,
        FsShl    = 4'b1000,
        FsShr    = 4'b1001,
        FsAsr    = 4'b1010,
        FsRol    = 4'b1011,
        FsRor    = 4'b1100
    } fun_sel_e;

    logic [Width-1:0] regs_q [NRegs];
    logic [Width-1:0] regs_d [NRegs];
    logic             wrap_q;
    logic             wrap_d;

    always_comb begin
        wrap_d = 1'b0;
        for (int k = 0; k < NRegs; k++) begin
            regs_d[k] = regs_q[k];
            if (bus.reg_sel[k]) begin
                case (bus.fun_sel)
                    FsDec: begin
                        regs_d[k] = regs_q[k] - Width'(1);
                        if (regs_q[k] == '0) wrap_d = 1'b1;
                    end
                    FsInc: begin
                        regs_d[k] = regs_q[k] + Width'(1);
                        if (&regs_q[k]) wrap_d = 1'b1;
                    end
                    FsLoad:   regs_d[k] = bus.data;
                    FsClear:  regs_d[k] = '0;
                    FsZext:   regs_d[k] = Width'(bus.data[7:0]);
                    FsLoadLo: regs_d[k][7:0] = bus.data[7:0];
                    // Indexed part-select keeps this legal (and equal to FsLoadLo) at Width=8.
                    FsLoadHi: regs_d[k][Width-1 -: 8] = bus.data[7:0];
                    FsSext:   regs_d[k] = Width'($signed(bus.data[7:0]));
                    FsShl:    regs_d[k] = {regs_q[k][Width-2:0], 1'b0};
                    FsShr:    regs_d[k] = {1'b0, regs_q[k][Width-1:1]};
                    FsAsr:    regs_d[k] = {regs_q[k][Width-1], regs_q[k][Width-1:1]};
                    FsRol:    regs_d[k] = {regs_q[k][Width-2:0], regs_q[k][Width-1]};
                    FsRor:    regs_d[k] = {regs_q[k][0], regs_q[k][Width-1:1]};
                    default:  regs_d[k] = regs_q[k];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NRegs; k++) begin
                regs_q[k] <= '0;
            end
            wrap_q <= 1'b0;
        end else begin
            for (int k = 0; k < NRegs; k++) begin
                regs_q[k] <= regs_d[k];
            end
            wrap_q <= wrap_d;
        end
    end

    // Selects beyond the bank (non power-of-two NRegs) read as zero.
    always_comb begin
        bus.out_a = '0;
        bus.out_b = '0;
        if (32'(bus.out_a_sel) < NRegs) bus.out_a = regs_q[bus.out_a_sel];
        if (32'(bus.out_b_sel) < NRegs) bus.out_b = regs_q[bus.out_b_sel];
    end

    assign bus.zero_a = (bus.out_a == '0);
    assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: arithmetic reference model checked every negedge,
// plus hand-computed literal expectations for each scenario.
module tb_param_register_file;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   started = 1'b0;

    param_register_file_if #(.Width(16), .NRegs(4)) bus ();

    param_register_file #(.Width(16), .NRegs(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    // Reference model: plain integer arithmetic on register values.
    int unsigned m_r [4];
    bit          m_wrap;

    always @(posedge clk) begin
        int unsigned v;
        int unsigned d8;
        bit          nw;
        if (rst) begin
            for (int k = 0; k < 4; k++) m_r[k] = 0;
            m_wrap = 1'b0;
        end else begin
            nw = 1'b0;
            d8 = int'(bus.data) & 'hFF;
            for (int k = 0; k < 4; k++) begin
                if (bus.reg_sel[k]) begin
                    v = m_r[k];
                    case (int'(bus.fun_sel))
                        0:  begin if (v == 0) nw = 1'b1; v = (v + 'hFFFF) % 'h10000; end
                        1:  begin if (v == 'hFFFF) nw = 1'b1; v = (v + 1) % 'h10000; end
                        2:  v = int'(bus.data);
                        3:  v = 0;
                        4:  v = d8;
                        5:  v = (v & 'hFF00) | d8;
                        6:  v = (v & 'h00FF) | (d8 * 256);
                        7:  v = (d8 >= 'h80) ? ('hFF00 + d8) : d8;
                        8:  v = (v * 2) % 'h10000;
                        9:  v = v / 2;
                        10: v = (v / 2) + ((v >= 'h8000) ? 'h8000 : 0);
                        11: v = ((v * 2) % 'h10000) + v / 'h8000;
                        12: v = (v / 2) + ((v % 2) * 'h8000);
                        default: v = v;
                    endcase
                    m_r[k] = v;
                end
            end
            m_wrap = nw;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("cyc_outA", 32'(bus.out_a), m_r[bus.out_a_sel]);
            check("cyc_outB", 32'(bus.out_b), m_r[bus.out_b_sel]);
            check("cyc_zeroA", 32'(bus.zero_a), 32'(m_r[bus.out_a_sel] == 0));
            check("cyc_wrap", 32'(bus.wrap), 32'(m_wrap));
        end
    end

    task automatic cyc(input logic r, input logic [3:0] f, input logic [3:0] s,
                       input logic [15:0] v);
        rst         = r;
        bus.fun_sel = f;
        bus.reg_sel = s;
        bus.data    = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string name, input int r, input logic [15:0] exp);
        bus.out_a_sel = 2'(r);
        #1;
        check(name, 32'(bus.out_a), 32'(exp));
        check({name, "_zero"}, 32'(bus.zero_a), 32'(exp == 16'h0));
    endtask

    task automatic chk_all_model();
        for (int r = 0; r < 4; r++) chk_reg($sformatf("model_r%0d", r), r, 16'(m_r[r]));
    endtask

    logic [3:0]  sh_fs  [5] = '{4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100};
    logic [15:0] sh_exp [5] = '{16'h0002, 16'h4000, 16'hC000, 16'h0003, 16'hC000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.out_a_sel = '0;
        bus.out_b_sel = 2'd1;
        cyc(1'b1, 4'b0011, 4'b0000, 16'h0);
        started = 1'b1;
        chk_reg("por_r0", 0, 16'h0000);
        check("por_wrap", 32'(bus.wrap), 32'd0);

        // Preload, then reset with a load pending on every register.
        cyc(1'b0, 4'b0010, 4'b0001, 16'h1111);
        cyc(1'b0, 4'b0010, 4'b0010, 16'h2222);
        cyc(1'b0, 4'b0010, 4'b0100, 16'h3333);
        cyc(1'b0, 4'b0010, 4'b1000, 16'h4444);
        chk_reg("pre_r3", 3, 16'h4444);
        cyc(1'b1, 4'b0010, 4'b1111, 16'h5555);
        for (int r = 0; r < 4; r++) chk_reg($sformatf("rst_r%0d", r), r, 16'h0000);
        check("rst_wrap", 32'(bus.wrap), 32'd0);

        // Load and byte operations on R2.
        cyc(1'b0, 4'b0010, 4'b0100, 16'hABCD); chk_reg("ld_abcd", 2, 16'hABCD);
        cyc(1'b0, 4'b0101, 4'b0100, 16'h0012); chk_reg("ld_lo", 2, 16'hAB12);
        cyc(1'b0, 4'b0110, 4'b0100, 16'h0034); chk_reg("ld_hi", 2, 16'h3412);
        cyc(1'b0, 4'b0111, 4'b0100, 16'h0080); chk_reg("ld_sext", 2, 16'hFF80);
        cyc(1'b0, 4'b0100, 4'b0100, 16'h0080); chk_reg("ld_zext", 2, 16'h0080);

        // Wrap pulses on R1.
        cyc(1'b0, 4'b0010, 4'b0010, 16'hFFFF);
        cyc(1'b0, 4'b0001, 4'b0010, 16'h0);
        chk_reg("inc_wrap_val", 1, 16'h0000);
        check("inc_wrap_flag", 32'(bus.wrap), 32'd1);
        cyc(1'b0, 4'b1110, 4'b0000, 16'h0);
        check("wrap_one_cycle", 32'(bus.wrap), 32'd0);
        cyc(1'b0, 4'b0000, 4'b0010, 16'h0);
        chk_reg("dec_wrap_val", 1, 16'hFFFF);
        check("dec_wrap_flag", 32'(bus.wrap), 32'd1);
        cyc(1'b0, 4'b0000, 4'b0010, 16'h0);
        chk_reg("dec_val", 1, 16'hFFFE);
        check("dec_nowrap", 32'(bus.wrap), 32'd0);

        // Shifts and rotates of 8001 on R3.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 4'b0010, 4'b1000, 16'h8001);
            cyc(1'b0, sh_fs[i], 4'b1000, 16'h0);
            chk_reg($sformatf("shift_fs%0d", int'(sh_fs[i])), 3, sh_exp[i]);
        end

        // Multi-hot increment, both ports on R0.
        cyc(1'b0, 4'b0010, 4'b0001, 16'h0005);
        cyc(1'b0, 4'b0010, 4'b0010, 16'h0009);
        cyc(1'b0, 4'b0001, 4'b0011, 16'h0);
        bus.out_a_sel = 2'd0;
        bus.out_b_sel = 2'd0;
        #1;
        check("multi_outA", 32'(bus.out_a), 32'h0006);
        check("multi_outB", 32'(bus.out_b), 32'h0006);
        chk_reg("multi_r1", 1, 16'h000A);
        chk_reg("multi_r2", 2, 16'h0080);
        chk_reg("multi_r3", 3, 16'hC000);
        bus.out_b_sel = 2'd2;

        // Reset coinciding with a wrapping increment.
        cyc(1'b0, 4'b0010, 4'b0010, 16'hFFFF);
        cyc(1'b1, 4'b0001, 4'b0010, 16'h0);
        chk_reg("rstmid_r1", 1, 16'h0000);
        check("rstmid_wrap", 32'(bus.wrap), 32'd0);
        cyc(1'b0, 4'b0010, 4'b0001, 16'h00C3);
        cyc(1'b0, 4'b1110, 4'b1111, 16'h1234);
        chk_reg("hold_r0", 0, 16'h00C3);
        check("hold_wrap", 32'(bus.wrap), 32'd0);
        chk_all_model();

        cyc(1'b0, 4'b1111, 4'b0000, 16'h0);
        started = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
